// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg
//   Shared constants and types for the nibble-serial subtractor.
//   Provides the FSM state encoding (IDLE, RUN, DONE), the nibble width,
//   a packed view of the result flags and a helper that derives the number
//   of nibble steps from an operand width.
package sub_serial_pkg;

  // Width of one arithmetic step; the serial datapath handles one nibble
  // per clock.
  localparam int NIBBLE_W = 4;

  // FSM encoding kept as plain constants so older tools and netlists that
  // expect a fixed 2-bit code keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packed bundle of the status flags produced alongside diff.
  typedef struct packed {
    logic borrow;
    logic ovfl;
    logic zero;
    logic neg;
  } flags_t;

  // Number of serial steps needed for an operand of the given width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/sub_serial_cla4.sv
// cla4
//   4-bit carry-lookahead adder used as the single arithmetic element of the
//   nibble-serial subtractor.
// Ports
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
//   pg    : group propagate (all four bits propagate)
//   gg    : group generate (the nibble generates a carry by itself)
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every internal carry is expanded directly from cin so no carry ripples
  // through more than two gate levels.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign cout = gg | (pg & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/sub_serial.sv
// sub_serial
//   Nibble-serial subtractor: computes a - b as a + ~b + 1, one nibble per
//   clock, least-significant nibble first, using a single cla4 instance.
//   A result takes WIDTH/4 RUN cycles followed by a one-cycle DONE.
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request; operands captured when idle or in the DONE cycle
//   a, b   : minuend, subtrahend (WIDTH bits)
//   busy   : high while a subtraction is in progress (RUN)
//   done   : one-cycle pulse, results valid
//   diff   : a - b modulo 2^WIDTH
//   borrow : unsigned a < b
//   ovfl   : signed two's-complement overflow
//   zero   : diff == 0
//   neg    : diff MSB
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Lower nibbles of the result; the top nibble comes straight from the
  // adder on the final step, so it never needs its own storage.
  logic [WIDTH-5:0] res_reg;
  logic [WIDTH-5:0] res_next;

  logic             capture;
  logic             last;
  logic [CW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum;
  logic             cout;
  logic             nib_pg_unused;
  logic             nib_gg_unused;
  logic [WIDTH-1:0] result;
  flags_t           flags_next;

  // Operands are only accepted outside RUN; start during RUN is ignored.
  assign capture = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last    = (cnt == LAST_NIB);

  // Nibble k starts at bit 4k; appending two zero bits to the counter gives
  // that offset without any multiplier.
  assign base  = {cnt, 2'b00};
  assign a_nib = a_reg[base +: NIBBLE_W];
  assign b_nib = ~b_reg[base +: NIBBLE_W];

  cla4 u_cla4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum),
    .cout (cout),
    .pg   (nib_pg_unused),
    .gg   (nib_gg_unused)
  );

  // Partial results shift in from the top so that after NIB-1 steps nibble 0
  // sits at bit 0 and the final adder nibble completes the word above them.
  generate
    if (WIDTH == 8) begin : g_res_single
      assign res_next = sum;
    end else begin : g_res_shift
      assign res_next = {sum, res_reg[WIDTH-5:4]};
    end
  endgenerate

  assign result = {sum, res_reg};

  // Flags are derived from the latched operands and the complete result so
  // they line up with diff on the final edge.
  always_comb begin
    flags_next        = '0;
    flags_next.borrow = ~cout;
    flags_next.ovfl   = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])
                      & (sum[3] ^ a_reg[WIDTH-1]);
    flags_next.zero   = ~|result;
    flags_next.neg    = sum[3];
  end

  // FSM, counter and datapath registers. The counter holds at NIB-1 on the
  // final step and only returns to 0 through a new capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovfl    <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else if (capture) begin
      state <= ST_RUN;
      a_reg <= a;
      b_reg <= b;
      cnt   <= '0;
      carry <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          carry   <= cout;
          res_reg <= res_next;
          if (last) begin
            state  <= ST_DONE;
            diff   <= result;
            borrow <= flags_next.borrow;
            ovfl   <= flags_next.ovfl;
            zero   <= flags_next.zero;
            neg    <= flags_next.neg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial
//   Directed self-checking bench for sub_serial at WIDTH=16. Each task drives
//   one scenario and compares outputs against hand-computed values.
module tb_sub_serial;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovfl;
  logic             zero;
  logic             neg;

  int n_cmp = 0;
  int n_bad = 0;

  sub_serial #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovfl   (ovfl),
    .zero   (zero),
    .neg    (neg)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for done; returns at the negedge
  // inside the DONE cycle, reporting busy cycles seen and whether done came.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    n_cmp++;
    if ({busy, done, diff, borrow, ovfl, zero, neg} !== 21'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {busy, done, diff, borrow, ovfl, zero, neg});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL idle_after_reset busy,done got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_basic();
    int bc;
    bit seen;
    run_op(16'h0005, 16'h0003, bc, seen);
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL basic_done_timeout got=%b want=1", seen);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_bad++;
      $display("[TB] FAIL basic_busy_cycles got=%0d want=4", bc);
    end
    n_cmp++;
    if (diff !== 16'h0002) begin
      n_bad++;
      $display("[TB] FAIL basic_diff got=%h want=0002", diff);
    end
    n_cmp++;
    if ({borrow, ovfl, zero, neg} !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL basic_flags got=%b want=0000", {borrow, ovfl, zero, neg});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL basic_done_pulse busy,done got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_borrow();
    int bc;
    bit seen;
    run_op(16'h0003, 16'h0005, bc, seen);
    n_cmp++;
    if ({seen, diff} !== {1'b1, 16'hFFFE}) begin
      n_bad++;
      $display("[TB] FAIL borrow_diff got=%b/%h want=1/fffe", seen, diff);
    end
    n_cmp++;
    if ({borrow, ovfl, zero, neg} !== 4'b1001) begin
      n_bad++;
      $display("[TB] FAIL borrow_flags got=%b want=1001", {borrow, ovfl, zero, neg});
    end
  endtask

  task automatic test_overflow();
    int bc;
    bit seen;
    run_op(16'h8000, 16'h0001, bc, seen);
    n_cmp++;
    if ({seen, diff} !== {1'b1, 16'h7FFF}) begin
      n_bad++;
      $display("[TB] FAIL ovfl_neg_diff got=%b/%h want=1/7fff", seen, diff);
    end
    n_cmp++;
    if ({borrow, ovfl, zero, neg} !== 4'b0100) begin
      n_bad++;
      $display("[TB] FAIL ovfl_neg_flags got=%b want=0100", {borrow, ovfl, zero, neg});
    end
    run_op(16'h7FFF, 16'hFFFF, bc, seen);
    n_cmp++;
    if ({seen, diff} !== {1'b1, 16'h8000}) begin
      n_bad++;
      $display("[TB] FAIL ovfl_pos_diff got=%b/%h want=1/8000", seen, diff);
    end
    n_cmp++;
    if ({borrow, ovfl, zero, neg} !== 4'b1101) begin
      n_bad++;
      $display("[TB] FAIL ovfl_pos_flags got=%b want=1101", {borrow, ovfl, zero, neg});
    end
  endtask

  task automatic test_equal();
    int bc;
    bit seen;
    run_op(16'h1234, 16'h1234, bc, seen);
    n_cmp++;
    if ({seen, diff, borrow, ovfl, zero, neg} !== {1'b1, 16'h0000, 4'b0010}) begin
      n_bad++;
      $display("[TB] FAIL equal_1234 got=%b/%h/%b want=1/0000/0010",
               seen, diff, {borrow, ovfl, zero, neg});
    end
    run_op(16'h0000, 16'h0000, bc, seen);
    n_cmp++;
    if ({seen, diff, borrow, ovfl, zero, neg} !== {1'b1, 16'h0000, 4'b0010}) begin
      n_bad++;
      $display("[TB] FAIL equal_zero got=%b/%h/%b want=1/0000/0010",
               seen, diff, {borrow, ovfl, zero, neg});
    end
  endtask

  // start stays high through RUN while the operand inputs keep changing.
  task automatic test_start_held();
    int busy_n;
    int done_n;
    int extra_n;
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1234;
    start = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
      a = 16'hFFFF - 16'(i * 16'h0111);
      b = 16'h0001 + 16'(i);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy_n, done_n} !== {32'd4, 32'd0}) begin
      n_bad++;
      $display("[TB] FAIL held_run busy/done cycles got=%0d/%0d want=4/0", busy_n, done_n);
    end
    n_cmp++;
    if ({done, diff, zero} !== {1'b1, 16'h0000, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL held_result done/diff/zero got=%b/%h/%b want=1/0000/1",
               done, diff, zero);
    end
    start = 1'b0;
    extra_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) extra_n++;
    end
    n_cmp++;
    if (extra_n !== 0) begin
      n_bad++;
      $display("[TB] FAIL held_no_extra_done got=%0d active cycles want=0", extra_n);
    end
  endtask

  // New start accepted in the DONE cycle; prior diff must hold until the
  // next result lands.
  task automatic test_back_to_back();
    int bc;
    int cyc;
    int hold_bad;
    bit seen;
    run_op(16'h0005, 16'h0003, bc, seen);
    a = 16'h0010;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    hold_bad = 0;
    while (!done && cyc < 20) begin
      if (diff !== 16'h0002) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (hold_bad !== 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_prior_hold got=%0d changed cycles want=0", hold_bad);
    end
    n_cmp++;
    if (cyc !== 5) begin
      n_bad++;
      $display("[TB] FAIL b2b_latency got=%0d want=5", cyc);
    end
    n_cmp++;
    if ({done, diff, borrow, ovfl, zero, neg} !== {1'b1, 16'h000F, 4'b0000}) begin
      n_bad++;
      $display("[TB] FAIL b2b_result got=%b/%h/%b want=1/000f/0000",
               done, diff, {borrow, ovfl, zero, neg});
    end
  endtask

  task automatic test_reset_mid_run();
    int bc;
    int done_n;
    bit seen;
    @(negedge clk);
    a = 16'h00AB;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, diff, borrow, ovfl, zero, neg} !== 21'd0) begin
      n_bad++;
      $display("[TB] FAIL midrun_reset_outputs got=%h want=0",
               {busy, done, diff, borrow, ovfl, zero, neg});
    end
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    n_cmp++;
    if (done_n !== 0) begin
      n_bad++;
      $display("[TB] FAIL midrun_no_done got=%0d want=0", done_n);
    end
    run_op(16'hFFFF, 16'h0000, bc, seen);
    n_cmp++;
    if ({seen, diff, borrow, ovfl, zero, neg} !== {1'b1, 16'hFFFF, 4'b0001}) begin
      n_bad++;
      $display("[TB] FAIL post_reset_op got=%b/%h/%b want=1/ffff/0001",
               seen, diff, {borrow, ovfl, zero, neg});
    end
  endtask

  initial begin
    $display("[TB] sub_serial directed bench, WIDTH=%0d", WIDTH);
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_equal();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
